// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter for the 2N-bit multiplier product, one bit per clock.
// Define PRODUCT_BCD_SEG_EN to add the registered active-low seven-segment output seg.
module product_bcd_converter #(
   parameter int unsigned N      = 4,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*N-1:0]        product,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
`ifdef PRODUCT_BCD_SEG_EN
   ,
   output logic [7*DIGITS-1:0]   seg
`endif
);

   localparam int unsigned PW    = 2 * N;
   localparam int unsigned CNT_W = (PW > 1) ? $clog2(PW) : 1;
   localparam int unsigned BW    = 4 * DIGITS;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e             state_q, state_d;
   logic [PW-1:0]      bin_q;
   logic [BW-1:0]      acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_q;

   logic [BW-1:0]      acc_adj;
   logic [BW-1:0]      acc_sh;
   logic [PW-1:0]      bin_sh;
   logic               carry;
   logic               accept;
   logic               last;

   assign accept = (state_q == StIdle) && in_valid;
   assign last   = (state_q == StShift) && (cnt_q == CNT_W'(PW - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid) state_d = StShift;
         StShift: if (last)     state_d = StDone;
         StDone:                state_d = StIdle;
         default:               state_d = StIdle;
      endcase
   end

   // Outputs decoded from state only
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
   end

   // Add-3 per digit (no inter-digit carry), then shift {acc, bin} left by one
   always_comb begin
      acc_adj = acc_q;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (acc_q[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
      {carry, acc_sh, bin_sh} = {acc_adj, bin_q, 1'b0};
   end

`ifdef PRODUCT_BCD_SEG_EN
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   logic [7*DIGITS-1:0] seg_d;

   always_comb begin
      seg_d = '0;
      for (int k = 0; k < int'(DIGITS); k++) seg_d[7*k +: 7] = seg_decode(acc_sh[4*k +: 4]);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
`ifdef PRODUCT_BCD_SEG_EN
         seg      <= {DIGITS{7'b1000000}};
`endif
      end else if (accept) begin
         bin_q <= product;
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (state_q == StShift) begin
         bin_q <= bin_sh;
         acc_q <= acc_sh;
         cnt_q <= cnt_q + CNT_W'(1);
         ovf_q <= ovf_q | carry;
         if (last) begin
            bcd      <= acc_sh;
            overflow <= ovf_q | carry;
`ifdef PRODUCT_BCD_SEG_EN
            seg      <= seg_d;
`endif
         end
      end
   end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomized self-checking bench: decimal-arithmetic reference model, DIGITS=3 and DIGITS=2 DUTs.
module tb_product_bcd_converter;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  product;
   logic        in_ready, out_valid, overflow;
   logic [11:0] bcd;
   logic        in_ready2, out_valid2, overflow2;
   logic [7:0]  bcd2;
`ifdef PRODUCT_BCD_SEG_EN
   logic [20:0] seg;
   logic [13:0] seg2;
`endif

   int compared   = 0;
   int mismatched = 0;

   int          pidx[$];
   logic [11:0] pb1[$];
   logic        po1[$];
   logic [7:0]  pb2[$];
   logic        po2[$];
`ifdef PRODUCT_BCD_SEG_EN
   logic [20:0] ps1[$];
`endif
   int          ready_low;

   always #5 clk = ~clk;

   product_bcd_converter #(.N(N), .DIGITS(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .product   (product),
      .out_valid (out_valid),
      .bcd       (bcd),
      .overflow  (overflow)
`ifdef PRODUCT_BCD_SEG_EN
      ,
      .seg       (seg)
`endif
   );

   product_bcd_converter #(.N(N), .DIGITS(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready2),
      .product   (product),
      .out_valid (out_valid2),
      .bcd       (bcd2),
      .overflow  (overflow2)
`ifdef PRODUCT_BCD_SEG_EN
      ,
      .seg       (seg2)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits of p modulo 10**digits, packed as BCD
   function automatic logic [15:0] ref_bcd(input int p, input int digits);
      logic [15:0] r;
      int v;
      r = '0;
      v = p;
      for (int k = 0; k < digits; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [27:0] ref_seg(input int p, input int digits);
      logic [6:0] tab [10];
      logic [27:0] r;
      int v;
      tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      r = '0;
      v = p;
      for (int k = 0; k < digits; k++) begin
         r[7*k +: 7] = tab[v % 10];
         v = v / 10;
      end
      return r;
   endfunction

   // Samples once per cycle at the falling edge; sample i follows rising edge E_i
   task automatic observe(input int cycles, input logic [7:0] later, input int drop_at);
      pidx.delete(); pb1.delete(); po1.delete(); pb2.delete(); po2.delete();
`ifdef PRODUCT_BCD_SEG_EN
      ps1.delete();
`endif
      ready_low = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (!in_ready) ready_low++;
         if (out_valid) begin
            pidx.push_back(i);
            pb1.push_back(bcd);
            po1.push_back(overflow);
            pb2.push_back(bcd2);
            po2.push_back(overflow2);
`ifdef PRODUCT_BCD_SEG_EN
            ps1.push_back(seg);
`endif
         end
         if (i == 0) product = later;
         if (i == drop_at) in_valid = 1'b0;
      end
   endtask

   task automatic run_one(input int p);
      in_valid = 1'b1;
      product  = 8'(p);
      observe(2*N + 3, 8'($urandom_range(0, 255)), 0);
      check("pulse_count", 64'(pidx.size()), 64'd1);
      if (pidx.size() > 0) begin
         check("latency", 64'(pidx[0]), 64'(2*N));
         check("bcd", 64'(pb1[0]), 64'(ref_bcd(p, 3)));
         check("overflow", 64'(po1[0]), 64'(p >= 1000));
         check("bcd_d2", 64'(pb2[0]), 64'(ref_bcd(p, 2)));
         check("overflow_d2", 64'(po2[0]), 64'(p >= 100));
`ifdef PRODUCT_BCD_SEG_EN
         check("seg", 64'(ps1[0]), 64'(ref_seg(p, 3)));
`endif
      end
      check("ready_low", 64'(ready_low), 64'(2*N + 1));
      check("bcd_hold", 64'(bcd), 64'(ref_bcd(p, 3)));
   endtask

   initial begin
      int p;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      product  = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_bcd", 64'(bcd), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
`ifdef PRODUCT_BCD_SEG_EN
      check("rst_seg", 64'(seg), 64'(ref_seg(0, 3)));
`endif
      rst_n = 1'b1;
      @(negedge clk);

      run_one(225);
      run_one(0);
      run_one(9);
      run_one(99);

      // Back-to-back with in_valid held: accepts on E0 and E10, product swapped mid-shift
      in_valid = 1'b1;
      product  = 8'd144;
      observe(4*N + 5, 8'd81, 2*N + 2);
      check("b2b_pulses", 64'(pidx.size()), 64'd2);
      if (pidx.size() == 2) begin
         check("b2b_first_at", 64'(pidx[0]), 64'(2*N));
         check("b2b_second_at", 64'(pidx[1]), 64'(4*N + 2));
         check("b2b_bcd0", 64'(pb1[0]), 64'h144);
         check("b2b_bcd1", 64'(pb1[1]), 64'h081);
      end

      // Reset three cycles into a conversion of 225
      in_valid = 1'b1;
      product  = 8'd225;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_bcd", 64'(bcd), 64'd0);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      check("mid_rst_overflow", 64'(overflow), 64'd0);
`ifdef PRODUCT_BCD_SEG_EN
      check("mid_rst_seg", 64'(seg), 64'(ref_seg(0, 3)));
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_one(56);

      for (int i = 0; i < 12; i++) begin
         p = int'($urandom_range(0, 255));
         run_one(p);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
